// File: rtl/bram_acc_pkg.sv
// Shared FSM state encoding and default sizing constants for the BRAM lane accumulator.
package bram_acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_LANES     = 4;
  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_ACC_W         = 32;
  localparam int DEF_AWIDTH        = 10;
  localparam int DEF_CNT_BIT       = 11;

endpackage

// File: rtl/bram_lane_accumulator_if.sv
// Two-port BRAM bus: BRAM0 (lane data source) and BRAM1 (result sink).
interface bram_lane_accumulator_if #(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH_1 = 32,
  parameter int DWIDTH_2 = 128
);
  logic [AWIDTH-1:0]   addr_b0_o;
  logic                ce_b0_o;
  logic                we_b0_o;
  logic [DWIDTH_1-1:0] d_b0_o;
  logic [DWIDTH_1-1:0] q_b0_i;
  logic [AWIDTH-1:0]   addr_b1_o;
  logic                ce_b1_o;
  logic                we_b1_o;
  logic [DWIDTH_2-1:0] d_b1_o;
  logic [DWIDTH_2-1:0] q_b1_i;

  modport master (
    output addr_b0_o, ce_b0_o, we_b0_o, d_b0_o,
    output addr_b1_o, ce_b1_o, we_b1_o, d_b1_o,
    input  q_b0_i, q_b1_i
  );

  modport slave (
    input  addr_b0_o, ce_b0_o, we_b0_o, d_b0_o,
    input  addr_b1_o, ce_b1_o, we_b1_o, d_b1_o,
    output q_b0_i, q_b1_i
  );
endinterface

// File: rtl/bram_lane_accumulator_lane.sv
// One lane accumulator: zero-extends the input and adds it, wrapping or clamping at full scale.
module lane_accumulator
  import bram_acc_pkg::*;
#(
  parameter int IN_W     = DEF_IN_DATA_WIDTH,
  parameter int ACC_W    = DEF_ACC_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  // One spare bit catches the carry so saturation can detect overflow.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, data_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (SATURATE && sum[ACC_W]) begin
        acc_d = '1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bram_lane_accumulator.sv
// Sums N BRAM0 rows lane-by-lane and writes the lane totals to one BRAM1 word.
// Optional BRAM_ACC_SATURATE_EN clamps each accumulator instead of wrapping.
module bram_lane_accumulator
  import bram_acc_pkg::*;
#(
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int AWIDTH        = DEF_AWIDTH,
  parameter int CNT_BIT       = DEF_CNT_BIT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_run_i,
  input  logic [CNT_BIT-1:0] run_count_i,
  input  logic [AWIDTH-1:0]  rd_base_i,
  input  logic [AWIDTH-1:0]  wr_base_i,
  bram_lane_accumulator_if.master mem,
  output logic               idle_o,
  output logic               read_o,
  output logic               write_o,
  output logic               done_o
);

  localparam int DWIDTH_1 = NUM_LANES * IN_DATA_WIDTH;
  localparam int DWIDTH_2 = NUM_LANES * ACC_W;

`ifdef BRAM_ACC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] count_q, count_d;
  logic [AWIDTH-1:0]  rd_base_q, rd_base_d;
  logic [AWIDTH-1:0]  wr_base_q, wr_base_d;
  logic               acc_clear;
  logic               acc_en;
  logic [DWIDTH_2-1:0] acc_flat;
  logic               unused_q_b1;

  assign unused_q_b1 = ^mem.q_b1_i;
  assign mem.we_b0_o = 1'b0;
  assign mem.d_b0_o  = {DWIDTH_1{1'b0}};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    count_d       = count_q;
    rd_base_d     = rd_base_q;
    wr_base_d     = wr_base_q;
    acc_clear     = 1'b0;
    acc_en        = 1'b0;
    idle_o        = 1'b0;
    read_o        = 1'b0;
    write_o       = 1'b0;
    done_o        = 1'b0;
    mem.addr_b0_o = '0;
    mem.ce_b0_o   = 1'b0;
    mem.addr_b1_o = '0;
    mem.ce_b1_o   = 1'b0;
    mem.we_b1_o   = 1'b0;
    mem.d_b1_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        idle_o = 1'b1;
        if (start_run_i) begin
          count_d   = run_count_i;
          rd_base_d = rd_base_i;
          wr_base_d = wr_base_i;
          cnt_d     = '0;
          acc_clear = 1'b1;
          state_d   = (run_count_i == '0) ? ST_WRITE : ST_READ;
        end
      end
      // Data returns one cycle after its address, so row i is summed during read i+1.
      ST_READ: begin
        read_o        = 1'b1;
        mem.ce_b0_o   = 1'b1;
        mem.addr_b0_o = rd_base_q + AWIDTH'(cnt_q);
        acc_en        = (cnt_q != '0);
        if (cnt_q == count_q - CNT_BIT'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_BIT'(1);
        end
      end
      ST_DRAIN: begin
        read_o  = 1'b1;
        acc_en  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        write_o       = 1'b1;
        mem.ce_b1_o   = 1'b1;
        mem.we_b1_o   = 1'b1;
        mem.addr_b1_o = wr_base_q;
        mem.d_b1_o    = acc_flat;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_accumulator #(
      .IN_W    (IN_DATA_WIDTH),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clear_i(acc_clear),
      .en_i   (acc_en),
      .data_i (mem.q_b0_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
      .acc_o  (acc_flat[k*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_bram_lane_accumulator.sv
// Scoreboard bench: two DUTs (ACC_W=32 and ACC_W=9) share stimulus and a BRAM0 model.
module tb_bram_lane_accumulator;

  localparam int NL  = 4;
  localparam int IW  = 8;
  localparam int AW  = 10;
  localparam int CB  = 11;
  localparam int D1  = NL * IW;
  localparam int D2A = NL * 32;
  localparam int D2B = NL * 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_run_i = 1'b0;
  logic [CB-1:0] run_count_i = '0;
  logic [AW-1:0] rd_base_i = '0;
  logic [AW-1:0] wr_base_i = '0;
  logic idle_a, read_a, write_a, done_a;
  logic idle_b, read_b, write_b, done_b;

  bram_lane_accumulator_if #(.AWIDTH(AW), .DWIDTH_1(D1), .DWIDTH_2(D2A)) mem_a ();
  bram_lane_accumulator_if #(.AWIDTH(AW), .DWIDTH_1(D1), .DWIDTH_2(D2B)) mem_b ();

  bram_lane_accumulator dut_a (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .rd_base_i(rd_base_i), .wr_base_i(wr_base_i), .mem(mem_a),
    .idle_o(idle_a), .read_o(read_a), .write_o(write_a), .done_o(done_a)
  );

  bram_lane_accumulator #(.ACC_W(9)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .rd_base_i(rd_base_i), .wr_base_i(wr_base_i), .mem(mem_b),
    .idle_o(idle_b), .read_o(read_b), .write_o(write_b), .done_o(done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  wr;
    logic [D2A-1:0] da;
    logic [D2B-1:0] db;
    int             done_cyc;
  } exp_t;

  logic [D1-1:0] bram0 [0:1023];
  exp_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_done = -1;
  int   runs_pushed = 0;
  int   dones_seen = 0;

  assign mem_a.q_b1_i = '0;
  assign mem_b.q_b1_i = '0;

  // BRAM0 model with one-cycle read latency, one read port per DUT
  always @(posedge clk) begin
    if (mem_a.ce_b0_o) mem_a.q_b0_i <= bram0[mem_a.addr_b0_o];
    if (mem_b.ce_b0_o) mem_b.q_b0_i <= bram0[mem_b.addr_b0_o];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: per-lane sum of the requested rows, reduced to each accumulator width
  task automatic pushExpected(input int n, input int rd, input int wr, input int c0);
    exp_t   e;
    longint s, sa, sb;
    e.wr = AW'(wr);
    e.da = '0;
    e.db = '0;
    for (int k = 0; k < NL; k++) begin
      s = 0;
      for (int r = 0; r < n; r++) s += longint'(bram0[(rd + r) % 1024][k*IW +: IW]);
`ifdef BRAM_ACC_SATURATE_EN
      sa = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
      sb = (s > 511) ? 511 : s;
`else
      sa = s % (64'd1 << 32);
      sb = s % 512;
`endif
      e.da[k*32 +: 32] = 32'(sa);
      e.db[k*9 +: 9]   = 9'(sb);
    end
    for (int r = 0; r < n; r++) addr_q.push_back((rd + r) % 1024);
    e.done_cyc = c0 + ((n == 0) ? 2 : n + 3);
    exp_q.push_back(e);
    runs_pushed++;
  endtask

  task automatic applyStimulus(input int n, input int rd, input int wr, input bit hold);
    int c0, lat;
    lat = (n == 0) ? 2 : n + 3;
    @(posedge clk); #1;
    start_run_i = 1'b1;
    run_count_i = CB'(n);
    rd_base_i   = AW'(rd);
    wr_base_i   = AW'(wr);
    c0 = cyc;
    pushExpected(n, rd, wr, c0);
    if (hold) begin
      pushExpected(n, rd, wr, c0 + lat + 1);
      repeat (lat + 2) @(posedge clk);
      #1 start_run_i = 1'b0;
      repeat (lat) @(posedge clk);
    end else begin
      @(posedge clk); #1 start_run_i = 1'b0;
      repeat (lat) @(posedge clk);
    end
  endtask

  task automatic resetMidRun(input int n, input int rd, input int wr);
    @(posedge clk); #1;
    start_run_i = 1'b1;
    run_count_i = CB'(n);
    rd_base_i   = AW'(rd);
    wr_base_i   = AW'(wr);
    addr_q.push_back(rd % 1024);
    addr_q.push_back((rd + 1) % 1024);
    @(posedge clk); #1 start_run_i = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle", {idle_a, read_a, write_a, done_a, idle_b, read_b, write_b, done_b}, 8'b1000_1000);
    repeat (4) @(posedge clk);
  endtask

  // Monitor: per-cycle output checks and scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (cyc > 0) begin
      checkOutput("onehot_a", $onehot({idle_a, read_a, write_a, done_a}), 1);
      checkOutput("onehot_b", $onehot({idle_b, read_b, write_b, done_b}), 1);
      checkOutput("b0_tied", {mem_a.we_b0_o, mem_a.d_b0_o, mem_b.we_b0_o, mem_b.d_b0_o}, 0);
      if (mem_a.ce_b0_o || mem_b.ce_b0_o) begin
        if (addr_q.size() == 0) begin
          checkOutput("unexpected_read", {mem_a.ce_b0_o, mem_b.ce_b0_o}, 0);
        end else begin
          a = addr_q.pop_front();
          checkOutput("rd_addr_a", mem_a.addr_b0_o, a);
          checkOutput("rd_addr_b", mem_b.addr_b0_o, a);
          checkOutput("rd_ctrl", {mem_a.ce_b0_o, mem_b.ce_b0_o, read_a, read_b}, 4'hF);
        end
      end else begin
        checkOutput("b0_quiet", {mem_a.addr_b0_o, mem_b.addr_b0_o}, 0);
      end
      if (mem_a.ce_b1_o || mem_a.we_b1_o || mem_b.ce_b1_o || mem_b.we_b1_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {mem_a.we_b1_o, mem_b.we_b1_o}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_ctrl", {mem_a.ce_b1_o, mem_a.we_b1_o, mem_b.ce_b1_o, mem_b.we_b1_o, write_a, write_b}, 6'h3F);
          checkOutput("wr_addr_a", mem_a.addr_b1_o, e.wr);
          checkOutput("wr_addr_b", mem_b.addr_b1_o, e.wr);
          checkOutput("wr_data_a", mem_a.d_b1_o, e.da);
          checkOutput("wr_data_b", mem_b.d_b1_o, e.db);
          checkOutput("wr_cycle", cyc, e.done_cyc - 1);
          cur_done = e.done_cyc;
        end
      end else begin
        checkOutput("b1_quiet_a", {mem_a.addr_b1_o, mem_a.d_b1_o}, 0);
        checkOutput("b1_quiet_b", {mem_b.addr_b1_o, mem_b.d_b1_o}, 0);
      end
      if (done_a || done_b) begin
        checkOutput("done_both", {done_a, done_b}, 2'b11);
        checkOutput("done_cycle", cyc, cur_done);
        dones_seen++;
      end
    end
  end

  initial begin
    int n, rd, wr;
    bit hold;
    for (int i = 0; i < 1024; i++) bram0[i] = D1'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_flags", {idle_a, read_a, write_a, done_a, idle_b, read_b, write_b, done_b}, 8'b1000_1000);
    checkOutput("rst_b1_a", {mem_a.ce_b1_o, mem_a.we_b1_o, mem_a.addr_b1_o}, 0);
    checkOutput("rst_b0_a", {mem_a.ce_b0_o, mem_a.addr_b0_o}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int r = 0; r < 3; r++) bram0[r] = {8'd4, 8'd3, 8'd2, 8'd1};
    applyStimulus(3, 0, 5, 1'b0);
    applyStimulus(0, 0, 7, 1'b0);
    applyStimulus(4, 1022, 9, 1'b0);
    for (int r = 100; r < 103; r++) bram0[r] = {24'($urandom), 8'hFF};
    applyStimulus(2, 100, 11, 1'b0);
    applyStimulus(3, 100, 12, 1'b0);
    resetMidRun(5, 200, 13);
    applyStimulus(3, 0, 14, 1'b0);
    applyStimulus(2, 300, 15, 1'b1);
    for (int t = 0; t < 25; t++) begin
      n    = $urandom_range(0, 7);
      rd   = $urandom_range(0, 1023);
      wr   = $urandom_range(0, 1023);
      hold = ($urandom_range(0, 5) == 0);
      applyStimulus(n, rd, wr, hold);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("addr_q_drained", addr_q.size(), 0);
    checkOutput("done_count", dones_seen, runs_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
